// File: rtl/shift_add_mult_ctrl_if.sv
`default_nettype none
// ============================================================================
// shift_add_mult_ctrl_if : operand/product handshake and shared-adder bus
// Revision 1.0
// ============================================================================
interface shift_add_mult_ctrl_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
);
  logic                 start_valid;
  logic                 start_ready;
  logic [WIDTH-1:0]     op_a;
  logic [WIDTH-1:0]     op_b;
  logic [WIDTH-1:0]     add_a;
  logic [WIDTH-1:0]     add_b;
  logic                 add_en;
  logic [WIDTH-1:0]     add_sum;
  logic                 add_cout;
  logic                 busy;
  logic [2*WIDTH-1:0]   prod;
  logic                 prod_valid;
  logic                 prod_ready;
  logic [CNT_W-1:0]     gated_cycles;

  modport master (
    output start_valid, op_a, op_b, add_sum, add_cout, prod_ready,
    input  start_ready, add_a, add_b, add_en, busy, prod, prod_valid, gated_cycles
  );

  modport slave (
    input  start_valid, op_a, op_b, add_sum, add_cout, prod_ready,
    output start_ready, add_a, add_b, add_en, busy, prod, prod_valid, gated_cycles
  );
endinterface
`default_nettype wire

// File: rtl/shift_add_mult_ctrl.sv
`default_nettype none
// ============================================================================
// shift_add_mult_ctrl : shift-and-add multiplier sequencer around a shared adder
// Revision 1.0
// ============================================================================
module shift_add_mult_ctrl #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  shift_add_mult_ctrl_if.slave  bus
);
  localparam int            CW   = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state;
  logic [WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]   acc_hi;
  logic [WIDTH-1:0]   acc_lo;
  logic [CW-1:0]      cnt;
  logic               start_ready;
  logic               busy;
  logic               prod_valid;
  logic [2*WIDTH-1:0] prod;
  logic [CNT_W-1:0]   gated_cycles;

  logic               add_en;
  logic [2*WIDTH-1:0] step;

  // Adder result is taken as-is so an approximate adder's error propagates uncorrected.
  assign add_en = (state == RUN) && acc_lo[0];
  assign step   = add_en ? {bus.add_cout, bus.add_sum, acc_lo[WIDTH-1:1]}
                         : {1'b0, acc_hi, acc_lo[WIDTH-1:1]};

  assign bus.add_en       = add_en;
  assign bus.add_a        = add_en ? acc_hi : '0;
  assign bus.add_b        = add_en ? mcand  : '0;
  assign bus.start_ready  = start_ready;
  assign bus.busy         = busy;
  assign bus.prod         = prod;
  assign bus.prod_valid   = prod_valid;
  assign bus.gated_cycles = gated_cycles;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      mcand        <= '0;
      acc_hi       <= '0;
      acc_lo       <= '0;
      cnt          <= '0;
      start_ready  <= 1'b0;
      busy         <= 1'b0;
      prod_valid   <= 1'b0;
      prod         <= '0;
      gated_cycles <= '0;
    end else begin
      case (state)
        IDLE: begin
          start_ready <= 1'b1;
          if (bus.start_valid && start_ready) begin
            start_ready <= 1'b0;
            busy        <= 1'b1;
            mcand       <= bus.op_a;
            acc_hi      <= '0;
            cnt         <= '0;
            // Zero operand: skip the adder and present a zero product.
            if (bus.op_a == '0 || bus.op_b == '0) begin
              acc_lo <= '0;
              state  <= DONE;
            end else begin
              acc_lo <= bus.op_b;
              state  <= RUN;
            end
          end
        end

        RUN: begin
          {acc_hi, acc_lo} <= step;
          cnt              <= cnt + CW'(1);
          if (!add_en && gated_cycles != {CNT_W{1'b1}}) begin
            gated_cycles <= gated_cycles + CNT_W'(1);
          end
          if (cnt == LAST) begin
            state <= DONE;
          end
        end

        DONE: begin
          if (!prod_valid) begin
            prod       <= {acc_hi, acc_lo};
            prod_valid <= 1'b1;
          end else if (bus.prod_ready) begin
            prod_valid  <= 1'b0;
            busy        <= 1'b0;
            start_ready <= 1'b1;
            state       <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end
endmodule
`default_nettype wire
